// File: rtl/iqmap_bpsk_if.sv
// rtl/iqmap_bpsk_if.sv - word input handshake and I/Q symbol output bundle for iqmap_bpsk
interface iqmap_bpsk_if;
  logic               ce;
  logic               valid_i;
  logic [127:0]       data_i;
  logic               ready_o;
  logic               valid_o;
  logic signed [10:0] ar;
  logic signed [10:0] ai;
  logic               last_o;

  modport master (
    output ce, valid_i, data_i,
    input  ready_o, valid_o, ar, ai, last_o
  );

  modport slave (
    input  ce, valid_i, data_i,
    output ready_o, valid_o, ar, ai, last_o
  );
endinterface

// File: rtl/iqmap_bpsk.sv
// rtl/iqmap_bpsk.sv - BPSK IQ mapper, 128-bit words serialized to +/-AMP symbols
// Optional IQMAP_BPSK_MSB_FIRST_EN: transmit data_i[127] first instead of data_i[0].
module iqmap_bpsk #(
  parameter int AMP = 1
) (
  input  logic         CLK,
  input  logic         RST,
  iqmap_bpsk_if.slave  bus
);

  localparam logic signed [10:0] P_POS = 11'(AMP);
  localparam logic signed [10:0] P_NEG = -P_POS;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             r_state;
  logic [6:0]         r_cnt;
  logic [127:0]       r_shift;
  logic [127:0]       r_hold;
  logic               r_hold_full;
  logic               r_valid;
  logic               r_last;
  logic signed [10:0] r_ar;

  logic [6:0]         w_idx;
  logic               w_bit;
  logic               w_ready;
  logic               w_accept;

`ifdef IQMAP_BPSK_MSB_FIRST_EN
  assign w_idx = 7'd127 - r_cnt;
`else
  assign w_idx = r_cnt;
`endif

  assign w_bit    = r_shift[w_idx];
  assign w_ready  = RST & ~r_hold_full;
  assign w_accept = bus.ce & bus.valid_i & w_ready;

  assign bus.ready_o = w_ready;
  assign bus.valid_o = r_valid;
  assign bus.ar      = r_ar;
  assign bus.ai      = 11'sd0;
  assign bus.last_o  = r_last;

  // Shift and hold contents are don't-care out of reset; only the flags are cleared.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state     <= IDLE;
      r_cnt       <= 7'd0;
      r_hold_full <= 1'b0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_ar        <= 11'sd0;
    end else if (bus.ce) begin
      case (r_state)
        IDLE: begin
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_ar    <= 11'sd0;
          if (w_accept) begin
            r_shift <= bus.data_i;
            r_cnt   <= 7'd0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_ar    <= w_bit ? P_NEG : P_POS;
          r_valid <= 1'b1;
          r_last  <= (r_cnt == 7'd127);
          r_cnt   <= r_cnt + 7'd1;
          // A held word wins the boundary; an empty hold lets a same-edge word bypass it.
          if (r_cnt == 7'd127) begin
            if (r_hold_full) begin
              r_shift     <= r_hold;
              r_hold_full <= 1'b0;
            end else if (w_accept) begin
              r_shift <= bus.data_i;
            end else begin
              r_state <= IDLE;
            end
          end else if (w_accept) begin
            r_hold      <= bus.data_i;
            r_hold_full <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iqmap_bpsk.sv
// tb/tb_iqmap_bpsk.sv - randomized self-checking bench for iqmap_bpsk against a word-queue model
module tb_iqmap_bpsk;
  localparam int AMP = 1;

  logic CLK = 1'b0;
  logic RST;
  iqmap_bpsk_if bus();

  iqmap_bpsk #(.AMP(AMP)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Model: queue of accepted words not yet started, plus the word being emitted.
  logic [127:0]       m_q[$];
  logic [127:0]       m_cur;
  bit                 m_cur_v = 0;
  int                 m_pos = 0;
  logic               exp_valid, exp_last, exp_ready;
  logic signed [10:0] exp_ar;

  function automatic bit model_bit(input logic [127:0] w, input int pos);
`ifdef IQMAP_BPSK_MSB_FIRST_EN
    return w[127 - pos];
`else
    return w[pos];
`endif
  endfunction

  function automatic logic [24:0] obs();
    return {bus.valid_o, bus.ar, bus.ai, bus.last_o, bus.ready_o};
  endfunction

  function automatic logic [24:0] want();
    return {exp_valid, exp_ar, 11'sd0, exp_last, exp_ready};
  endfunction

  function automatic logic [127:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick(input bit rst, input bit ce, input bit v, input logic [127:0] d);
    bit acc, was_v, finished;
    RST = rst;
    bus.ce = ce;
    bus.valid_i = v;
    bus.data_i = d;
    if (!rst) begin
      m_q.delete();
      m_cur_v = 0;
      m_pos = 0;
      exp_valid = 0;
      exp_ar = 11'sd0;
      exp_last = 0;
    end else if (ce) begin
      acc = v && (m_q.size() == 0);
      was_v = m_cur_v;
      finished = 0;
      if (m_cur_v) begin
        exp_valid = 1;
        exp_ar = model_bit(m_cur, m_pos) ? 11'(-AMP) : 11'(AMP);
        exp_last = (m_pos == 127);
        m_pos++;
        if (m_pos == 128) begin
          finished = 1;
          m_cur_v = 0;
        end
      end else begin
        exp_valid = 0;
        exp_ar = 11'sd0;
        exp_last = 0;
      end
      if (acc) m_q.push_back(d);
      if ((!was_v || finished) && m_q.size() > 0) begin
        m_cur = m_q.pop_front();
        m_cur_v = 1;
        m_pos = 0;
      end
    end
    exp_ready = rst && (m_q.size() == 0);
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 1, rnd_word());
      tests++;
      if ({bus.ready_o, bus.valid_o, bus.ar, bus.ai} !== {1'b0, 1'b0, 11'sd0, 11'sd0}) begin
        fails++;
        $display("FAIL reset_hold cyc=%0d got rdy=%b v=%b ar=%0d ai=%0d want 0 0 0 0",
                 i, bus.ready_o, bus.valid_o, bus.ar, bus.ai);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick(1, 1, 0, '0);
      tests++;
      if ({bus.ready_o, bus.valid_o} !== 2'b10) begin
        fails++;
        $display("FAIL reset_release cyc=%0d got rdy=%b v=%b want 1 0", i, bus.ready_o, bus.valid_o);
      end
    end
  endtask

  task automatic test_single();
    int nvalid, nlast, lastpos;
    logic signed [10:0] first_exp;
`ifdef IQMAP_BPSK_MSB_FIRST_EN
    first_exp = 11'(AMP);
`else
    first_exp = 11'(-AMP);
`endif
    nvalid = 0; nlast = 0; lastpos = -1;
    tick(1, 1, 1, 128'h1);
    for (int i = 0; i < 132; i++) begin
      tick(1, 1, 0, '0);
      tests++;
      if (obs() !== want()) begin
        fails++;
        $display("FAIL single cyc=%0d got %h want %h", i, obs(), want());
      end
      if (i == 0) begin
        tests++;
        if ({bus.valid_o, bus.ar} !== {1'b1, first_exp}) begin
          fails++;
          $display("FAIL single_first got v=%b ar=%0d want v=1 ar=%0d", bus.valid_o, bus.ar, first_exp);
        end
      end
      if (bus.valid_o === 1'b1) nvalid++;
      if (bus.last_o === 1'b1) begin nlast++; lastpos = i; end
    end
    tests++;
    if (nvalid != 128 || nlast != 1 || lastpos != 127) begin
      fails++;
      $display("FAIL single_count got valid=%0d last=%0d at %0d want 128 1 127", nvalid, nlast, lastpos);
    end
  endtask

  task automatic test_back_to_back();
    int run, maxrun;
    run = 0; maxrun = 0;
    tick(1, 1, 1, {32{4'hA}});
    tick(1, 1, 1, {32{4'h5}});
    if (bus.valid_o === 1'b1) run = 1;
    tests++;
    if (bus.ready_o !== 1'b0) begin
      fails++;
      $display("FAIL b2b_hold got rdy=%b want 0", bus.ready_o);
    end
    for (int i = 0; i < 262; i++) begin
      tick(1, 1, 0, '0);
      tests++;
      if (obs() !== want()) begin
        fails++;
        $display("FAIL b2b cyc=%0d got %h want %h", i, obs(), want());
      end
      if (bus.valid_o === 1'b1) begin
        run++;
        if (run > maxrun) maxrun = run;
      end else run = 0;
    end
    tests++;
    if (maxrun != 256) begin
      fails++;
      $display("FAIL b2b_run got %0d want 256", maxrun);
    end
  endtask

  task automatic test_bypass();
    int nlow, guard;
    nlow = 0; guard = 0;
    tick(1, 1, 1, rnd_word());
    while (m_pos != 127 && guard < 200) begin
      tick(1, 1, 0, '0);
      guard++;
      if (bus.ready_o !== 1'b1) nlow++;
    end
    tick(1, 1, 1, rnd_word());
    tests++;
    if ({bus.last_o, bus.ready_o} !== 2'b11 || guard >= 200) begin
      fails++;
      $display("FAIL bypass_edge got last=%b rdy=%b guard=%0d want 1 1", bus.last_o, bus.ready_o, guard);
    end
    for (int i = 0; i < 132; i++) begin
      tick(1, 1, 0, '0);
      if (bus.ready_o !== 1'b1) nlow++;
      tests++;
      if (obs() !== want()) begin
        fails++;
        $display("FAIL bypass cyc=%0d got %h want %h", i, obs(), want());
      end
    end
    tests++;
    if (nlow != 0) begin
      fails++;
      $display("FAIL bypass_hold got ready-low cycles=%0d want 0", nlow);
    end
  endtask

  task automatic test_stall();
    logic [24:0] frozen;
    tick(1, 1, 1, rnd_word());
    for (int i = 0; i < 41; i++) tick(1, 1, 0, '0);
    frozen = obs();
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, 1'($urandom), rnd_word());
      tests++;
      if (obs() !== frozen || obs() !== want()) begin
        fails++;
        $display("FAIL stall cyc=%0d got %h want %h", i, obs(), frozen);
      end
    end
    for (int i = 0; i < 90; i++) begin
      tick(1, 1, 0, '0);
      tests++;
      if (obs() !== want()) begin
        fails++;
        $display("FAIL stall_resume cyc=%0d got %h want %h", i, obs(), want());
      end
    end
  endtask

  task automatic test_abort();
    tick(1, 1, 1, rnd_word());
    tick(1, 1, 1, rnd_word());
    for (int i = 0; i < 69; i++) tick(1, 1, 0, '0);
    tick(0, 1, 0, '0);
    tests++;
    if ({bus.valid_o, bus.ar, bus.last_o, bus.ready_o} !== {1'b0, 11'sd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL abort got v=%b ar=%0d last=%b rdy=%b want 0 0 0 0",
               bus.valid_o, bus.ar, bus.last_o, bus.ready_o);
    end
    for (int i = 0; i < 6; i++) begin
      tick(1, 1, 0, '0);
      tests++;
      if ({bus.valid_o, bus.ready_o} !== 2'b01) begin
        fails++;
        $display("FAIL abort_release cyc=%0d got v=%b rdy=%b want 0 1", i, bus.valid_o, bus.ready_o);
      end
    end
  endtask

  task automatic test_msb_word();
    logic [127:0] w;
    logic signed [10:0] e0, e127;
    w = 128'h1 << 127;
`ifdef IQMAP_BPSK_MSB_FIRST_EN
    e0 = 11'(-AMP); e127 = 11'(AMP);
`else
    e0 = 11'(AMP); e127 = 11'(-AMP);
`endif
    tick(1, 1, 1, w);
    for (int i = 0; i < 130; i++) begin
      tick(1, 1, 0, '0);
      tests++;
      if (obs() !== want()) begin
        fails++;
        $display("FAIL msb_word cyc=%0d got %h want %h", i, obs(), want());
      end
      if (i == 0 || i == 127) begin
        tests++;
        if (bus.ar !== (i == 0 ? e0 : e127)) begin
          fails++;
          $display("FAIL msb_edge cyc=%0d got ar=%0d want %0d", i, bus.ar, (i == 0 ? e0 : e127));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2500; i++) begin
      tick($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0, 1'($urandom), rnd_word());
      tests++;
      if (obs() !== want()) begin
        fails++;
        $display("FAIL random cyc=%0d got %h want %h", i, obs(), want());
      end
    end
  endtask

  initial begin
    RST = 1'b0;
    bus.ce = 1'b0;
    bus.valid_i = 1'b0;
    bus.data_i = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_bypass();
    test_stall();
    test_abort();
    test_msb_word();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
